// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the convolution compute slots
package conv_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } alloc_state_t;

   typedef struct packed {
      logic signed [3:0] dx;
      logic signed [3:0] dy;
   } tap_offset_t;

   // Row-major tap index to window offset, centred on zero.
   function automatic tap_offset_t tap_offset(input logic [4:0] tap, input int k);
      tap_offset_t o;
      int r;
      r    = (k - 1) / 2;
      o.dx = 4'(int'(tap) % k - r);
      o.dy = 4'(int'(tap) / k - r);
      return o;
   endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// rtl/conv_tap_counter.sv - walks the K x K window taps in row-major order
module conv_tap_counter #(
   parameter int K = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   output logic signed [3:0] dx,
   output logic signed [3:0] dy,
   output logic [4:0]        tap,
   output logic              last
);
   import conv_pkg::*;

   localparam logic [4:0]        LAST_TAP = 5'(K * K - 1);
   localparam logic signed [3:0] R        = 4'((K - 1) / 2);
   localparam tap_offset_t       START    = tap_offset(5'd0, K);

   assign last = (tap == LAST_TAP);

   always_ff @(posedge clk) begin
      if (!rst) begin
         tap <= '0;
         dx  <= '0;
         dy  <= '0;
      end else if (clear) begin
         tap <= '0;
         dx  <= START.dx;
         dy  <= START.dy;
      end else if (advance && !last) begin
         tap <= tap + 5'd1;
         if (dx == R) begin
            dx <= -R;
            dy <= dy + 4'sd1;
         end else begin
            dx <= dx + 4'sd1;
         end
      end
   end

endmodule

// File: rtl/conv_allocator.sv
// rtl/conv_allocator.sv - one compute slot: fetch a K x K window and return its weighted sum
module conv_allocator #(
   parameter int K      = 3,
   parameter int DATA_W = conv_pkg::DATA_W,
   parameter int ACC_W  = conv_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        image_dim,
   input  logic              select,
   input  logic [7:0]        center_x,
   input  logic [7:0]        center_y,
   output logic              busy,
   output logic              pix_req,
   input  logic              pix_gnt,
   output logic [7:0]        pix_x,
   output logic [7:0]        pix_y,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   output logic [4:0]        weight_idx,
   input  logic [DATA_W-1:0] weight_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic [7:0]        res_x,
   output logic [7:0]        res_y,
   output logic              collision
);
   import conv_pkg::*;

   alloc_state_t             state, state_nxt;
   logic [7:0]               cx, cy;
   logic [ACC_W-1:0]         acc;
   logic signed [3:0]        dx, dy;
   logic [4:0]               tap;
   logic                     last;
   logic                     tc_clear, tc_advance;
   logic [9:0]               tx, ty;
   logic                     in_range;
   logic signed [2*DATA_W:0] w_ext, p_ext, prod;

   conv_tap_counter #(.K(K)) u_tap (
      .clk     (clk),
      .rst     (rst),
      .clear   (tc_clear),
      .advance (tc_advance),
      .dx      (dx),
      .dy      (dy),
      .tap     (tap),
      .last    (last)
   );

   // Ten bits hold cx+dx for any 8-bit centre; bit 9 set means negative.
   assign tx       = {2'b00, cx} + {{6{dx[3]}}, dx};
   assign ty       = {2'b00, cy} + {{6{dy[3]}}, dy};
   assign in_range = !tx[9] && !ty[9] && (tx[8:0] < {1'b0, image_dim})
                                      && (ty[8:0] < {1'b0, image_dim});

   assign w_ext = {{(DATA_W+1){weight_data[DATA_W-1]}}, weight_data};
   assign p_ext = {{(DATA_W+1){1'b0}}, pix_data};
   assign prod  = w_ext * p_ext;

   always_comb begin
      state_nxt  = state;
      tc_clear   = 1'b0;
      tc_advance = 1'b0;
      case (state)
         IDLE: begin
            if (select) begin
               state_nxt = ISSUE;
               tc_clear  = 1'b1;
            end
         end
         ISSUE: begin
            if (!in_range) begin
               tc_advance = 1'b1;
               state_nxt  = last ? DONE : ISSUE;
            end else if (pix_gnt) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (pix_valid) begin
               tc_advance = 1'b1;
               state_nxt  = last ? DONE : ISSUE;
            end
         end
         DONE: begin
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign pix_req    = (state == ISSUE) && in_range;
   assign pix_x      = pix_req ? tx[7:0] : 8'd0;
   assign pix_y      = pix_req ? ty[7:0] : 8'd0;
   assign weight_idx = tap;
   assign res_valid  = (state == DONE);
   assign res_data   = acc;
   assign res_x      = cx;
   assign res_y      = cy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cx        <= '0;
         cy        <= '0;
         acc       <= '0;
         collision <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && select) begin
            cx  <= center_x;
            cy  <= center_y;
            acc <= '0;
         end
         if (state != IDLE && select) collision <= 1'b1;
         if (state == WAIT && pix_valid)
            acc <= acc + {{(ACC_W-2*DATA_W-1){prod[2*DATA_W]}}, prod};
      end
   end

endmodule

// File: tb/tb_conv_allocator.sv
// tb/tb_conv_allocator.sv - self-checking bench for conv_allocator
module tb_conv_allocator;

   localparam int K = 3, R = 1, DATA_W = 8, ACC_W = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        image_dim;
   logic              select;
   logic [7:0]        center_x, center_y;
   logic              busy, pix_req, pix_gnt, pix_valid;
   logic [7:0]        pix_x, pix_y;
   logic [DATA_W-1:0] pix_data;
   logic [4:0]        weight_idx;
   logic [DATA_W-1:0] weight_data;
   logic              res_valid, res_ready;
   logic [ACC_W-1:0]  res_data;
   logic [7:0]        res_x, res_y;
   logic              collision;

   logic signed [7:0] wt [0:31];
   assign weight_data = wt[weight_idx];

   conv_allocator #(.K(K), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .image_dim(image_dim), .select(select),
      .center_x(center_x), .center_y(center_y), .busy(busy),
      .pix_req(pix_req), .pix_gnt(pix_gnt), .pix_x(pix_x), .pix_y(pix_y),
      .pix_valid(pix_valid), .pix_data(pix_data), .weight_idx(weight_idx),
      .weight_data(weight_data), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_x(res_x), .res_y(res_y), .collision(collision)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0, tot_cnt = 0;
   int pix_mode = 0, pix_const = 1, pix_seed = 0;
   int gdelay = 0, vdelay = 0;
   bit resp_en = 1'b1;
   int hs_cnt = 0;
   int hs_q[$];
   int exp_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int pixel(input int x, input int y);
      if (pix_mode == 0) return pix_const;
      return (x * 37 + y * 11 + pix_seed) & 255;
   endfunction

   task automatic set_weights(input int mode);
      for (int i = 0; i < 32; i++) begin
         if (i >= K * K)     wt[i] = 8'sd0;
         else if (mode == 0) wt[i] = 8'(i + 1);
         else if (mode == 1) wt[i] = -8'sd128;
         else                wt[i] = 8'($urandom_range(0, 255));
      end
   endtask

   // Reference: scan the window, count cycles per tap, wrap the sum to ACC_W.
   task automatic model(input int cx, input int cy, input int dim,
                        output longint sum, output int cyc);
      logic signed [ACC_W-1:0] w;
      sum = 0; cyc = 1; exp_q.delete();
      for (int dy = -R; dy <= R; dy++)
         for (int dx = -R; dx <= R; dx++) begin
            int tx, ty;
            tx = cx + dx; ty = cy + dy;
            if (tx >= 0 && tx < dim && ty >= 0 && ty < dim) begin
               sum += longint'(wt[(dy + R) * K + dx + R]) * pixel(tx, ty);
               cyc += 2;
               exp_q.push_back(tx * 256 + ty);
            end else cyc += 1;
         end
      w = sum[ACC_W-1:0];
      sum = longint'(w);
   endtask

   // Pixel source: grants after gdelay request cycles, returns data vdelay cycles later.
   initial begin
      int gcnt = 0, vcnt = 0;
      bit pending = 1'b0;
      logic [7:0] lat = '0;
      pix_gnt = 1'b0; pix_valid = 1'b0; pix_data = '0;
      forever begin
         @(negedge clk);
         if (!resp_en) begin
            pending = 1'b0; gcnt = 0;
         end else begin
            pix_valid = 1'b0;
            if (pending) begin
               if (vcnt >= vdelay) begin
                  pix_valid = 1'b1; pix_data = lat; pending = 1'b0;
               end else vcnt++;
            end
            pix_gnt = 1'b0;
            if (pix_req) begin
               if (gcnt >= gdelay) begin
                  pix_gnt = 1'b1; lat = 8'(pixel(pix_x, pix_y));
                  pending = 1'b1; vcnt = 0; gcnt = 0;
                  hs_cnt++; hs_q.push_back(pix_x * 256 + pix_y);
               end else gcnt++;
            end else gcnt = 0;
         end
      end
   end

   task automatic run_window(input int cx, input int cy, input int dim, input int gd,
                             input int vd, input int hold, input bit collide,
                             output int cyc, output longint got, output int rx, output int ry);
      image_dim = 8'(dim); gdelay = gd; vdelay = vd; hs_cnt = 0; hs_q.delete();
      @(negedge clk); #1;
      select = 1'b1; center_x = 8'(cx); center_y = 8'(cy);
      @(posedge clk); #1;
      select = 1'b0; cyc = 1;
      while (!res_valid && cyc < 2000) begin
         @(posedge clk); #1; cyc++;
      end
      got = longint'($signed(res_data)); rx = int'(res_x); ry = int'(res_y);
      if (!res_valid) begin
         check("res_valid timeout", 0, 1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         if (collide && i == 0) begin
            select = 1'b1; center_x = 8'(cx ^ 8'h55);
         end
         @(posedge clk); #1;
         select = 1'b0;
         check("hold res_valid", res_valid, 1);
         check("hold res_data", longint'($signed(res_data)), got);
         check("hold res_x", res_x, rx);
      end
      @(negedge clk); #1; res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
      check("busy after handshake", busy, 0);
   endtask

   task automatic check_coords();
      check("handshake count", hs_q.size(), exp_q.size());
      for (int i = 0; i < hs_q.size() && i < exp_q.size(); i++)
         check("tap coordinate", hs_q[i], exp_q[i]);
   endtask

   typedef struct {
      int cx, cy, dim, wmode, pconst;
      longint exp_sum;
      int exp_cyc;
   } vec_t;

   initial begin
      vec_t vecs[6];
      int cyc, rx, ry, n, m_cyc;
      longint got, m_sum;

      vecs[0] = '{10, 10, 230, 0, 1, 45, 19};
      vecs[1] = '{0, 0, 230, 1, 255, -130560, 14};
      vecs[2] = '{229, 5, 230, 0, 2, 54, 16};
      vecs[3] = '{0, 0, 1, 0, 3, 15, 11};
      vecs[4] = '{5, 0, 1, 0, 7, 0, 10};
      vecs[5] = '{254, 254, 255, 0, 1, 12, 14};

      set_weights(0);
      rst = 1'b0; select = 1'b1; image_dim = 8'd230;
      center_x = 8'd33; center_y = 8'd44; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 0);
      check("reset pix_req", pix_req, 0);
      check("reset res_valid", res_valid, 0);
      check("reset res_data", res_data, 0);
      check("reset res_x", res_x, 0);
      check("reset res_y", res_y, 0);
      check("reset collision", collision, 0);
      check("reset weight_idx", weight_idx, 0);
      check("reset pix_x", pix_x, 0);
      @(negedge clk);
      select = 1'b0; rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         set_weights(vecs[i].wmode);
         pix_mode = 0; pix_const = vecs[i].pconst;
         model(vecs[i].cx, vecs[i].cy, vecs[i].dim, m_sum, m_cyc);
         run_window(vecs[i].cx, vecs[i].cy, vecs[i].dim, 0, 0,
                    (i == 0) ? 5 : 0, (i == 0), cyc, got, rx, ry);
         check("vector res_data", got, vecs[i].exp_sum);
         check("vector cycle", cyc, vecs[i].exp_cyc);
         check("vector res_x", rx, vecs[i].cx);
         check("vector res_y", ry, vecs[i].cy);
         check_coords();
         if (i == 0) check("collision set", collision, 1);
      end

      set_weights(0); pix_mode = 0; pix_const = 1;
      model(10, 10, 230, m_sum, m_cyc);
      run_window(10, 10, 230, 3, 4, 0, 1'b0, cyc, got, rx, ry);
      check("stall res_data", got, 45);
      check("stall pix handshakes", hs_cnt, 9);
      check_coords();

      image_dim = 8'd230; gdelay = 0; vdelay = 20; hs_cnt = 0; hs_q.delete();
      @(negedge clk); #1;
      select = 1'b1; center_x = 8'd10; center_y = 8'd10;
      @(posedge clk); #1;
      select = 1'b0; n = 0;
      while (hs_cnt < 4 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("reached tap 3 wait", hs_cnt, 4);
      @(negedge clk); #1;
      rst = 1'b0; resp_en = 1'b0; pix_gnt = 1'b0; pix_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1; pix_valid = 1'b1; pix_data = 8'd99;
      @(posedge clk); #1;
      check("stray valid busy", busy, 0);
      check("stray valid res_valid", res_valid, 0);
      check("stray valid res_data", res_data, 0);
      check("collision cleared", collision, 0);
      @(negedge clk); #1;
      pix_valid = 1'b0; resp_en = 1'b1;
      run_window(10, 10, 230, 0, 0, 0, 1'b0, cyc, got, rx, ry);
      check("after reset res_data", got, 45);
      check("after reset cycle", cyc, 19);

      for (int t = 0; t < 25; t++) begin
         int dim, cx, cy, gd, vd, hold;
         dim = $urandom_range(1, 255);
         cx = $urandom_range(0, dim + 1); if (cx > 255) cx = 255;
         cy = $urandom_range(0, dim + 1); if (cy > 255) cy = 255;
         gd = $urandom_range(0, 2); vd = $urandom_range(0, 2);
         hold = $urandom_range(0, 2);
         set_weights(2); pix_mode = 1; pix_seed = $urandom_range(0, 255);
         model(cx, cy, dim, m_sum, m_cyc);
         run_window(cx, cy, dim, gd, vd, hold, 1'b0, cyc, got, rx, ry);
         check("random res_data", got, m_sum);
         check("random res_x", rx, cx);
         check("random res_y", ry, cy);
         check_coords();
         if (gd == 0 && vd == 0) check("random cycle", cyc, m_cyc);
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
